// File: rtl/morse_key_sequencer.sv
// Morse key front end: sync, debounce, mark/gap timing and
// per-character symbol assembly for the segment decoder.
module morse_key_sequencer #(
  parameter int TICK_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 5,
  parameter int DASH_TICKS     = 200,
  parameter int CHAR_GAP_TICKS = 300,
  parameter int WORD_GAP_TICKS = 700,
  parameter int CNT_W          = 12
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic       key_in,
  output logic       data_valid,
  output logic [2:0] char_index,
  output logic [5:0] char_data,
  output logic       symbol_err,
  output logic       key_active
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] CGAP_C = CNT_W'(CHAR_GAP_TICKS);
  localparam logic [CNT_W-1:0] WGAP_C = CNT_W'(WORD_GAP_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MARK,
    S_GAP,
    S_WORD
  } state_t;

  logic [1:0]       r_sync;
  logic [PW-1:0]    r_pre;
  logic [DW-1:0]    r_db;
  logic             r_key;
  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_dur;
  logic [CNT_W-1:0] w_dur_nx;
  logic [CNT_W-1:0] w_dur_inc;
  logic [4:0]       r_sr;
  logic [4:0]       w_sr_nx;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cnt_nx;
  logic             r_ovf;
  logic             w_ovf_nx;
  logic             w_emit_chr;
  logic             w_emit_err;
  logic             w_emit_spc;
  logic             w_tick;
  logic             w_key_s;
  logic             w_fire;
  logic             w_press;
  logic             w_release;
  logic             w_sym;
  logic [5:0]       w_mask6;

  assign w_tick  = (r_pre == PRE_MAX);
  assign w_key_s = r_sync[1];
  // Edges are taken from the debounce toggle itself, so they land on a tick
  assign w_fire    = w_tick && (w_key_s != r_key) && (r_db == DB_LAST);
  assign w_press   = w_fire & ~r_key;
  assign w_release = w_fire & r_key;
  assign w_dur_inc = (r_dur == '1) ? r_dur : r_dur + CNT_W'(1);
  assign w_sym     = (w_dur_inc >= DASH_C);
  assign w_mask6   = (6'd1 << r_cnt) - 6'd1;
  assign key_active = r_key;

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      r_sync <= '0;
      r_pre  <= '0;
      r_db   <= '0;
      r_key  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], key_in};
      r_pre  <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick) begin
        if (w_key_s == r_key) begin
          r_db <= '0;
        end else if (r_db == DB_LAST) begin
          r_db  <= '0;
          r_key <= ~r_key;
        end else begin
          r_db <= r_db + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dur   <= '0;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_dur   <= w_dur_nx;
      r_sr    <= w_sr_nx;
      r_cnt   <= w_cnt_nx;
      r_ovf   <= w_ovf_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_dur_nx   = r_dur;
    w_sr_nx    = r_sr;
    w_cnt_nx   = r_cnt;
    w_ovf_nx   = r_ovf;
    w_emit_chr = 1'b0;
    w_emit_err = 1'b0;
    w_emit_spc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_state_nx = S_MARK;
          w_dur_nx   = '0;
        end
      end
      S_MARK: begin
        // Release shares its tick, so the final length is the incremented one
        if (w_release) begin
          if (r_cnt < 3'd5) begin
            w_sr_nx  = {r_sr[3:0], w_sym};
            w_cnt_nx = r_cnt + 3'd1;
          end else begin
            w_ovf_nx = 1'b1;
          end
          w_state_nx = S_GAP;
          w_dur_nx   = '0;
        end else if (w_tick) begin
          w_dur_nx = w_dur_inc;
        end
      end
      S_GAP: begin
        if (w_press) begin
          w_state_nx = S_MARK;
          w_dur_nx   = '0;
        end else if (w_tick) begin
          w_dur_nx = w_dur_inc;
          if (w_dur_inc == CGAP_C) begin
            w_emit_err = r_ovf;
            w_emit_chr = ~r_ovf;
            w_sr_nx    = '0;
            w_cnt_nx   = '0;
            w_ovf_nx   = 1'b0;
            w_state_nx = S_WORD;
          end
        end
      end
      S_WORD: begin
        if (w_press) begin
          w_state_nx = S_MARK;
          w_dur_nx   = '0;
        end else if (w_tick) begin
          w_dur_nx = w_dur_inc;
          if (w_dur_inc == WGAP_C) begin
            w_emit_spc = 1'b1;
            w_state_nx = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      data_valid <= 1'b0;
      symbol_err <= 1'b0;
      char_index <= '0;
      char_data  <= '0;
    end else begin
      data_valid <= w_emit_chr | w_emit_spc;
      symbol_err <= w_emit_err;
      if (w_emit_chr) begin
        char_index <= r_cnt - 3'd1;
        char_data  <= {1'b0, r_sr & w_mask6[4:0]};
      end else if (w_emit_spc) begin
        char_index <= 3'd5;
        char_data  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Bench for morse_key_sequencer: a tick-level Morse model predicts
// every emitted character, checked each cycle plus literal pins.
module tb_morse_key_sequencer;

  localparam int TD = 4;
  localparam int DB = 2;
  localparam int DASH = 6;
  localparam int CG = 8;
  localparam int WG = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_in;
  logic       data_valid;
  logic [2:0] char_index;
  logic [5:0] char_data;
  logic       symbol_err;
  logic       key_active;

  morse_key_sequencer #(
    .TICK_DIV(TD),
    .DEBOUNCE_TICKS(DB),
    .DASH_TICKS(DASH),
    .CHAR_GAP_TICKS(CG),
    .WORD_GAP_TICKS(WG),
    .CNT_W(8)
  ) dut (
    .clk_100Mhz(clk),
    .reset(reset),
    .key_in(key_in),
    .data_valid(data_valid),
    .char_index(char_index),
    .char_data(char_data),
    .symbol_err(symbol_err),
    .key_active(key_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int idx;
    int data;
    int lo;
    int hi;
  } ev_t;

  ev_t exp_q[$];
  int  cap_kind[$];
  int  cap_idx[$];
  int  cap_data[$];
  int  checks = 0;
  int  fails = 0;
  bit  started = 1'b0;
  ev_t e_cur;

  int m_n = 0;
  int m_bits = 0;
  bit m_ovf = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int cap_i(input int i);
    return (i < cap_idx.size()) ? cap_idx[i] : -1;
  endfunction

  function automatic int cap_d(input int i);
    return (i < cap_data.size()) ? cap_data[i] : -1;
  endfunction

  function automatic int cap_k(input int i);
    return (i < cap_kind.size()) ? cap_kind[i] : -1;
  endfunction

  always @(negedge clk) begin
    if (started && !reset && (data_valid || symbol_err)) begin
      cap_kind.push_back(symbol_err ? 1 : 0);
      cap_idx.push_back(int'(char_index));
      cap_data.push_back(int'(char_data));
      chk("both_pulses", int'(data_valid && symbol_err), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", cyc, -1);
      end else begin
        e_cur = exp_q.pop_front();
        chk("kind", symbol_err ? 1 : 0, e_cur.kind);
        if (!symbol_err) begin
          chk("char_index", int'(char_index), e_cur.idx);
          chk("char_data", int'(char_data), e_cur.data);
        end
        chk("timing", int'(cyc >= e_cur.lo && cyc <= e_cur.hi), 1);
      end
    end
  end

  task automatic ticks(input int n);
    repeat (n * TD) @(negedge clk);
  endtask

  task automatic add_sym(input int n);
    if (m_n < 5) begin
      m_bits = (m_bits << 1) | ((n >= DASH) ? 1 : 0);
      m_n++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic mark(input int n);
    key_in = 1'b1;
    ticks(n);
    add_sym(n);
  endtask

  task automatic push_ev(input int k, input int i, input int d, input int at);
    ev_t e;
    e.kind = k;
    e.idx  = i;
    e.data = d;
    e.lo   = at - 4;
    e.hi   = at + 6;
    exp_q.push_back(e);
  endtask

  // A press on the exact threshold tick wins, hence strict comparisons
  task automatic gap(input int g);
    int c;
    c = cyc;
    key_in = 1'b0;
    if ((m_n > 0 || m_ovf) && g > CG) begin
      push_ev(m_ovf ? 1 : 0, m_n - 1, m_bits, c + TD * (DB + CG));
      m_n = 0;
      m_bits = 0;
      m_ovf = 1'b0;
      if (g > WG) push_ev(0, 5, 0, c + TD * (DB + WG));
    end
    ticks(g);
  endtask

  int base;
  bit seen;

  initial begin
    reset  = 1'b1;
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data_valid", int'(data_valid), 0);
    chk("rst_char_index", int'(char_index), 0);
    chk("rst_char_data", int'(char_data), 0);
    chk("rst_symbol_err", int'(symbol_err), 0);
    chk("rst_key_active", int'(key_active), 0);
    reset = 1'b0;
    started = 1'b1;
    ticks(2);

    seen = 1'b0;
    key_in = 1'b1;
    repeat (TD) begin
      @(negedge clk);
      if (key_active) seen = 1'b1;
    end
    key_in = 1'b0;
    repeat (10 * TD) begin
      @(negedge clk);
      if (key_active) seen = 1'b1;
    end
    chk("glitch_key_active", int'(seen), 0);
    chk("glitch_no_pulse", cap_kind.size(), 0);

    base = cap_kind.size();
    key_in = 1'b1;
    ticks(1);
    chk("ka_before_debounce", int'(key_active), 0);
    ticks(2);
    chk("ka_after_debounce", int'(key_active), 1);
    add_sym(3);
    gap(2);
    mark(9);
    gap(40);
    ticks(10);
    chk("A_count", cap_kind.size() - base, 2);
    chk("A_index", cap_i(base), 1);
    chk("A_data", cap_d(base), 6'b000001);
    chk("A_space_index", cap_i(base + 1), 5);
    chk("A_space_data", cap_d(base + 1), 0);
    chk("A_hold_index", int'(char_index), 5);

    base = cap_kind.size();
    mark(6);
    gap(40);
    chk("T_index", cap_i(base), 0);
    chk("T_data", cap_d(base), 6'b000001);
    mark(5);
    gap(40);
    chk("E_index", cap_i(base + 2), 0);
    chk("E_data", cap_d(base + 2), 6'b000000);

    base = cap_kind.size();
    mark(6); gap(2);
    mark(6); gap(2);
    mark(5); gap(2);
    mark(6); gap(40);
    chk("Q_index", cap_i(base), 3);
    chk("Q_data", cap_d(base), 6'b001101);

    base = cap_kind.size();
    for (int i = 0; i < 4; i++) begin
      mark(6);
      gap(2);
    end
    mark(6);
    gap(40);
    chk("five_index", cap_i(base), 4);
    chk("five_data", cap_d(base), 6'b011111);

    base = cap_kind.size();
    for (int i = 0; i < 5; i++) begin
      mark(3);
      gap(2);
    end
    mark(3);
    gap(40);
    mark(6);
    gap(40);
    chk("ovf_kind", cap_k(base), 1);
    chk("ovf_space", cap_i(base + 1), 5);
    chk("after_ovf_kind", cap_k(base + 2), 0);
    chk("after_ovf_index", cap_i(base + 2), 0);
    chk("after_ovf_data", cap_d(base + 2), 6'b000001);

    base = cap_kind.size();
    mark(3);
    gap(8);
    mark(6);
    gap(40);
    chk("press_wins_count", cap_kind.size() - base, 2);
    chk("press_wins_index", cap_i(base), 1);
    chk("press_wins_data", cap_d(base), 6'b000001);

    base = cap_kind.size();
    mark(3);
    gap(20);
    mark(3);
    gap(40);
    chk("word_edge_count", cap_kind.size() - base, 3);
    chk("word_edge_second", cap_i(base + 1), 0);

    base = cap_kind.size();
    mark(3); gap(2);
    mark(6); gap(2);
    key_in = 1'b1;
    ticks(4);
    reset = 1'b1;
    key_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_data_valid", int'(data_valid), 0);
    chk("mid_rst_char_index", int'(char_index), 0);
    chk("mid_rst_char_data", int'(char_data), 0);
    chk("mid_rst_symbol_err", int'(symbol_err), 0);
    chk("mid_rst_key_active", int'(key_active), 0);
    m_n = 0;
    m_bits = 0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ticks(40);
    chk("post_rst_silent", cap_kind.size() - base, 0);
    chk("drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
